// File: rtl/sniff_uart_tx.sv
// sniff_uart_tx: FIFO-buffered UART 8N1 transmitter for the sniffer's saved-byte stream.
// Overruns drop the incoming byte and raise a sticky overflow flag; there is no backpressure.
module sniff_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH        = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             data_in,
    input  logic                   write,
    input  logic                   clear_ovf,
    output logic                   tx,
    output logic                   busy,
    output logic                   fifo_full,
    output logic                   fifo_empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int BC_W  = $clog2(CLKS_PER_BIT);

    localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(CLKS_PER_BIT - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state, state_n;
    logic [BC_W-1:0]    bc, bc_n;
    logic [2:0]         bit_idx, bit_n;
    logic [7:0]         shift, shift_n;
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [7:0]         mem [DEPTH];
    logic [LVL_W-1:0]   level_n;
    logic               pop, push, drop;
    logic               tx_n, busy_n;

    // NOTE: every signal gets a default before the case so no path leaves a latch behind.
    always_comb begin
        state_n = state;
        bc_n    = bc;
        bit_n   = bit_idx;
        shift_n = shift;
        pop     = 1'b0;

        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = mem[rd_ptr];
                    bc_n    = '0;
                    state_n = START;
                end
            end
            START: begin
                if (bc == BC_LAST) begin
                    bc_n    = '0;
                    bit_n   = '0;
                    state_n = DATA;
                end else begin
                    bc_n = bc + BC_W'(1);
                end
            end
            DATA: begin
                if (bc == BC_LAST) begin
                    bc_n    = '0;
                    shift_n = shift >> 1;
                    if (bit_idx == 3'd7) state_n = STOP;
                    else                 bit_n   = bit_idx + 3'd1;
                end else begin
                    bc_n = bc + BC_W'(1);
                end
            end
            STOP: begin
                if (bc == BC_LAST) begin
                    bc_n = '0;
                    // Chain straight into the next start bit so queued bytes leave gap-free.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_n = mem[rd_ptr];
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    bc_n = bc + BC_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        // tx and busy are derived from next-state values so their registers line up with the FSM.
        unique case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            default: tx_n = 1'b1;
        endcase
    end

    always_comb begin
        push    = write && (!fifo_full || pop);
        drop    = write && fifo_full && !pop;
        level_n = level;
        unique case ({push, pop})
            2'b10:   level_n = level + LVL_W'(1);
            2'b01:   level_n = level - LVL_W'(1);
            default: level_n = level;
        endcase
        busy_n = (state_n != IDLE) || (level_n != '0);
    end

    // NOTE: the storage array has no reset; pointers and level define which entries are valid.
    always_ff @(posedge clk) begin
        if (rst_n && push) mem[wr_ptr] <= data_in;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            bc         <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            level      <= '0;
            fifo_full  <= 1'b0;
            fifo_empty <= 1'b1;
            overflow   <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            bc         <= bc_n;
            bit_idx    <= bit_n;
            shift      <= shift_n;
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            level      <= level_n;
            fifo_full  <= (level_n == LVL_FULL);
            fifo_empty <= (level_n == '0);
            if (drop)           overflow <= 1'b1;
            else if (clear_ovf) overflow <= 1'b0;
            tx         <= tx_n;
            busy       <= busy_n;
        end
    end

endmodule

// File: tb/tb_sniff_uart_tx.sv
// Directed and randomized bench for sniff_uart_tx: a line-level UART receiver decodes tx
// and compares every byte with a queue of bytes the FIFO rules say must be sent.
module tb_sniff_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_in;
    logic       write;
    logic       clear_ovf;
    logic       tx;
    logic       busy;
    logic       fifo_full;
    logic       fifo_empty;
    logic [2:0] level;
    logic       overflow;

    int total = 0;
    int bad   = 0;
    int rst_cnt = 0;
    logic [7:0] exp_q [$];

    sniff_uart_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .write      (write),
        .clear_ovf  (clear_ovf),
        .tx         (tx),
        .busy       (busy),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .level      (level),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rst_n === 1'b0) rst_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle;
        int n = 0;
        while (busy !== 1'b0 && n < 2000) begin
            tick();
            n++;
        end
        check("idle_timeout", busy, 0);
    endtask

    task automatic put(input logic [7:0] b, input bit accepted);
        data_in = b;
        write   = 1'b1;
        tick();
        write   = 1'b0;
        if (accepted) exp_q.push_back(b);
    endtask

    // UART receiver: samples each bit near its centre; frames cut by a reset are discarded.
    initial begin : monitor
        logic [7:0] b;
        logic       stop_bit;
        int         rc;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                rc = rst_cnt;
                repeat (CPB / 2) @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    repeat (CPB) @(negedge clk);
                    b[k] = tx;
                end
                repeat (CPB) @(negedge clk);
                stop_bit = tx;
                if (rc == rst_cnt) begin
                    check("rx_stop_bit", stop_bit, 1);
                    check("rx_expected_pending", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) check("rx_byte", b, exp_q.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [9:0] frame;
        logic [7:0] b;
        logic [7:0] burst [5];
        int         n;
        int         lvl_max;
        int         tx_bad;

        rst_n = 1'b0; write = 1'b0; clear_ovf = 1'b0; data_in = 8'h00;
        repeat (3) tick();
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_full", fifo_full, 0);
        check("rst_empty", fifo_empty, 1);
        check("rst_level", level, 0);
        check("rst_ovf", overflow, 0);
        rst_n = 1'b1;
        tick();

        // Single byte: exact line waveform, cycle by cycle.
        put(8'hA5, 1'b1);
        check("single_level_e0", level, 1);
        check("single_empty_e0", fifo_empty, 0);
        check("single_busy_e0", busy, 1);
        check("single_tx_e0", tx, 1);
        tick();
        check("single_level_e1", level, 0);
        frame = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 10 * CPB; i++) begin
            check("single_tx_bit", tx, frame[i / CPB]);
            check("single_busy_frame", busy, 1);
            tick();
        end
        check("single_busy_end", busy, 0);
        check("single_tx_end", tx, 1);
        check("single_level_end", level, 0);

        // Burst of three: gap-free frames, peak level 2.
        data_in = 8'h31; write = 1'b1; tick();
        exp_q.push_back(8'h31);
        lvl_max = level;
        data_in = 8'h32; tick();
        exp_q.push_back(8'h32);
        if (level > lvl_max) lvl_max = level;
        data_in = 8'h33; tick();
        exp_q.push_back(8'h33);
        write = 1'b0;
        if (level > lvl_max) lvl_max = level;
        n = 2;
        while (busy === 1'b1 && n < 1000) begin
            tick();
            n++;
            if (level > lvl_max) lvl_max = level;
        end
        check("burst_cycles", n - 1, 3 * 10 * CPB);
        check("burst_level_peak", lvl_max, 2);

        // Overflow: six writes into a 4-deep FIFO.
        for (int i = 1; i <= 6; i++) begin
            data_in = 8'(i);
            write   = 1'b1;
            tick();
            if (i <= 5) exp_q.push_back(8'(i));
            if (i == 5) begin
                check("ovf_level_e4", level, 4);
                check("ovf_full_e4", fifo_full, 1);
                check("ovf_flag_e4", overflow, 0);
            end
        end
        write = 1'b0;
        check("ovf_flag_e5", overflow, 1);
        check("ovf_level_e5", level, 4);
        data_in = 8'hEE; write = 1'b1; clear_ovf = 1'b1;
        tick();
        write = 1'b0;
        check("ovf_set_beats_clear", overflow, 1);
        tick();
        clear_ovf = 1'b0;
        check("ovf_cleared", overflow, 0);
        wait_idle();
        check("ovf_level_drained", level, 0);

        // Push accepted on the pop cycle while full.
        for (int i = 0; i < 5; i++) burst[i] = 8'($urandom);
        for (int i = 0; i < 5; i++) put(burst[i], 1'b1);
        repeat (36) tick();
        check("pp_level_before", level, 4);
        check("pp_full_before", fifo_full, 1);
        put(8'h77, 1'b1);
        check("pp_level_after", level, 4);
        check("pp_ovf_after", overflow, 0);
        check("pp_tx_restart", tx, 0);
        wait_idle();
        check("pp_ovf_end", overflow, 0);

        // Reset during data bit 3 of 0x00 with two bytes still queued.
        put(8'h00, 1'b0);
        put(8'($urandom), 1'b0);
        put(8'($urandom), 1'b0);
        repeat (15) tick();
        rst_n = 1'b0; data_in = 8'h5A; write = 1'b1;
        tick();
        rst_n = 1'b1; write = 1'b0;
        check("mid_rst_tx", tx, 1);
        check("mid_rst_level", level, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_empty", fifo_empty, 1);
        tx_bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0) tx_bad++;
        end
        check("mid_rst_quiet", tx_bad, 0);

        // Random bursts up to DEPTH+1 bytes from idle are lossless.
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, DEPTH + 1);
            for (int j = 0; j < n; j++) put(8'($urandom), 1'b1);
            wait_idle();
            check("rburst_ovf", overflow, 0);
        end

        // Pointer wrap-around: ten random bytes spaced more than one frame apart.
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            put(b, 1'b1);
            repeat (10 * CPB + 3) tick();
        end
        wait_idle();
        check("wrap_ovf", overflow, 0);
        repeat (4 * CPB) tick();
        check("rx_all_received", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
